data_mem_ctrl: RTL and testbench

Data-memory responder for the RV32I core. It services the load/store requests issued by the control unit's MemRead/MemWrite decode, and owns a word-organised on-chip data array. It performs byte, half and word access with little-endian lane selection, sign or zero extension, alignment and range checking, and a configurable wait-state count. While an access is in flight it stalls the pipeline through a handshake.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/data_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// fault-cause codes and the controller state encoding.
package dmem_pkg;

  // Load encodings (funct3 of LOAD instructions)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (funct3 of STORE instructions)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Fault causes reported on fault_cause
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_RANGE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering between the 32-bit array word and the core:
// byte enables plus replicated store data, and extended load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Per-lane enable and data: a byte is replicated to all lanes, a half to
  // both halves, so the enable alone decides which lanes change.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_en[gi] = (funct3[1:0] == 2'b00) ? (byte_off == 2'(gi)) :
                         (funct3[1:0] == 2'b01) ? (byte_off[1] == 1'(gi / 2)) :
                                                  1'b1;
    assign store_word[8*gi +: 8] =
                         (funct3[1:0] == 2'b00) ? store_data[7:0] :
                         (funct3[1:0] == 2'b01) ? store_data[8*(gi % 2) +: 8] :
                                                  store_data[8*gi +: 8];
  end

  // Pick the addressed byte/half and apply sign or zero extension.
  always_comb begin
    byte_sel  = raw_word[7:0];
    half_sel  = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
    load_data = 32'h0;
    case (byte_off)
      2'd0:    byte_sel = raw_word[7:0];
      2'd1:    byte_sel = raw_word[15:8];
      2'd2:    byte_sel = raw_word[23:16];
      default: byte_sel = raw_word[31:24];
    endcase
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = raw_word;
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory responder: captures a load/store request, checks it,
// waits WAIT_CYCLES, then accesses the word array and reports completion.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int         AW        = ADDR_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              is_write_reg;
  logic [2:0]        funct3_reg;
  logic [AW-1:0]     addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              fault_reg;
  logic [1:0]        cause_reg;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       raw_reg;
  logic [ADDR_W-1:0] rd_idx;

  logic              req;
  logic              ld_ok, st_ok, illegal, range_bad, misalign;
  logic [1:0]        cause_next;
  logic              access_now;
  logic [3:0]        byte_en;
  logic [31:0]       store_word, load_word;

  assign req        = mem_read | mem_write;
  assign access_now = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);
  assign stall      = rst_n & req & (state_reg != ST_DONE);

  assign rdata       = rdata_reg;
  assign fault       = fault_reg;
  assign fault_cause = cause_reg;

  // Classify the incoming request; illegal beats out-of-range beats misaligned.
  always_comb begin
    ld_ok      = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
    st_ok      = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    illegal    = (mem_read & mem_write) | (mem_read & ~ld_ok) | (mem_write & ~st_ok);
    range_bad  = |addr[31:AW];
    misalign   = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b0;
    endcase
    cause_next = illegal   ? CAUSE_ILLEGAL :
                 range_bad ? CAUSE_RANGE :
                 misalign  ? CAUSE_MISALIGN : CAUSE_NONE;
  end

  dmem_lane_align u_lane_align (
    .funct3     (funct3_reg),
    .byte_off   (addr_reg[1:0]),
    .store_data (wdata_reg),
    .raw_word   (raw_reg),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_word)
  );

  // Read address follows the live request while idle so the word is already
  // registered when a zero-wait access reaches its final BUSY cycle.
  assign rd_idx = (state_reg == ST_IDLE) ? addr[AW-1:2] : addr_reg[AW-1:2];

  // Array: lane-masked write on the access cycle, registered read every cycle.
  always_ff @(posedge clk) begin
    if (access_now && is_write_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[addr_reg[AW-1:2]][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
    raw_reg <= mem[rd_idx];
  end

  // Control FSM: capture and check in IDLE, count wait states in BUSY,
  // present the one-cycle completion/fault status in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      is_write_reg <= 1'b0;
      funct3_reg   <= 3'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      rdata_reg    <= 32'h0;
      fault_reg    <= 1'b0;
      cause_reg    <= CAUSE_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            is_write_reg <= mem_write;
            funct3_reg   <= funct3;
            addr_reg     <= addr[AW-1:0];
            wdata_reg    <= wdata;
            if (cause_next != CAUSE_NONE) begin
              state_reg <= ST_DONE;
              fault_reg <= 1'b1;
              cause_reg <= cause_next;
              if (mem_read) rdata_reg <= 32'h0;
            end else begin
              state_reg <= ST_BUSY;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            if (!is_write_reg) rdata_reg <= load_word;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          fault_reg <= 1'b0;
          cause_reg <= CAUSE_NONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with three instances: WAIT_CYCLES=1, 4, 0.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n       [3];
  logic        mem_read    [3];
  logic        mem_write   [3];
  logic [2:0]  funct3      [3];
  logic [31:0] addr        [3];
  logic [31:0] wdata       [3];
  logic [31:0] rdata       [3];
  logic        stall       [3];
  logic        fault       [3];
  logic [1:0]  fault_cause [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_W      (10),
      .WAIT_CYCLES ((gi == 0) ? 1 : (gi == 1) ? 4 : 0)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n[gi]),
      .mem_read    (mem_read[gi]),
      .mem_write   (mem_write[gi]),
      .funct3      (funct3[gi]),
      .addr        (addr[gi]),
      .wdata       (wdata[gi]),
      .rdata       (rdata[gi]),
      .stall       (stall[gi]),
      .fault       (fault[gi]),
      .fault_cause (fault_cause[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request (called just after a rising edge) and wait for DONE.
  // cyc = number of stalled cycles before DONE, -1 if DONE never came.
  task automatic access(input int u, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int cyc,
                        output logic flt, output logic [1:0] cs, output logic [31:0] rdv);
    mem_read[u] = rd; mem_write[u] = wr; funct3[u] = f3; addr[u] = a; wdata[u] = wd;
    cyc = -1; flt = 1'b0; cs = 2'd0; rdv = 32'h0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!stall[u]) begin
        cyc = n; flt = fault[u]; cs = fault_cause[u]; rdv = rdata[u];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic release_req(input int u);
    mem_read[u] = 1'b0; mem_write[u] = 1'b0;
  endtask

  // One transaction plus its checks; prints one line per transaction.
  task automatic run(input string tag, input int u, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int exp_cyc, input logic [1:0] exp_cs, input bit chk_rd,
                     input logic [31:0] exp_rd);
    int          cyc;
    logic        flt;
    logic [1:0]  cs;
    logic [31:0] rdv;
    access(u, rd, wr, f3, a, wd, cyc, flt, cs, rdv);
    $display("xact %-10s u=%0d rd=%b wr=%b f3=%b addr=%h wd=%h cyc=%0d fault=%b cause=%0d rdata=%h",
             tag, u, rd, wr, f3, a, wd, cyc, flt, cs, rdv);
    chk({tag, ".cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, ".fault"}, {31'h0, flt}, {31'h0, exp_cs != 2'd0});
    chk({tag, ".cause"}, {30'h0, cs}, {30'h0, exp_cs});
    if (chk_rd) chk({tag, ".rdata"}, rdv, exp_rd);
  endtask

  logic [31:0] model [4];

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst_n[u] = 1'b0; mem_read[u] = 1'b0; mem_write[u] = 1'b0;
      funct3[u] = 3'd0; addr[u] = 32'h0; wdata[u] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", {31'h0, stall[0]}, 32'h0);
    @(negedge clk);
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdata", rdata[0], 32'h0);
    chk("rst.fault", {31'h0, fault[0]}, 32'h0);
    chk("rst.cause", {30'h0, fault_cause[0]}, 32'h0);

    // 1: word store/load, WAIT_CYCLES=1 -> 3 stalled cycles
    run("t1.sw",  0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 2'd0, 0, 32'h0);
    run("t1.lw",  0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 2'd0, 1, 32'hDEADBEEF);

    // 2: byte lane write and extended reads
    run("t2.sb",  0, 0, 1, 3'b000, 32'h11, 32'h00000080, 3, 2'd0, 1, 32'hDEADBEEF);
    run("t2.lb",  0, 1, 0, 3'b000, 32'h11, 32'h0,        3, 2'd0, 1, 32'hFFFFFF80);
    run("t2.lbu", 0, 1, 0, 3'b100, 32'h11, 32'h0,        3, 2'd0, 1, 32'h00000080);
    run("t2.lw",  0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 2'd0, 1, 32'hDEAD80EF);
    run("t2.lh",  0, 1, 0, 3'b001, 32'h12, 32'h0,        3, 2'd0, 1, 32'hFFFFDEAD);
    run("t2.lhu", 0, 1, 0, 3'b101, 32'h10, 32'h0,        3, 2'd0, 1, 32'h000080EF);

    // 3: misaligned faults
    run("t3.lh",  0, 1, 0, 3'b001, 32'h13, 32'h0,        1, 2'd1, 1, 32'h0);
    release_req(0);
    @(negedge clk);
    chk("t3.pulse", {31'h0, fault[0]}, 32'h0);
    @(posedge clk); #1;
    run("t3.lw",  0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 2'd0, 1, 32'hDEAD80EF);
    run("t3.sw",  0, 0, 1, 3'b010, 32'h12, 32'h11111111, 1, 2'd1, 1, 32'hDEAD80EF);
    run("t3.chk", 0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 2'd0, 1, 32'hDEAD80EF);

    // 4: illegal and range faults
    run("t4.rdwr", 0, 1, 1, 3'b010, 32'h10,   32'h0, 1, 2'd2, 0, 32'h0);
    run("t4.f011", 0, 1, 0, 3'b011, 32'h10,   32'h0, 1, 2'd2, 0, 32'h0);
    run("t4.sf100", 0, 0, 1, 3'b100, 32'h10,  32'h0, 1, 2'd2, 0, 32'h0);
    run("t4.range", 0, 1, 0, 3'b010, 32'h1000, 32'h0, 1, 2'd3, 1, 32'h0);
    run("t4.prio", 0, 1, 0, 3'b011, 32'h1001, 32'h0, 1, 2'd2, 0, 32'h0);
    run("t4.rgmis", 0, 1, 0, 3'b010, 32'h1001, 32'h0, 1, 2'd3, 0, 32'h0);
    release_req(0);

    // 5: reset mid-access aborts the store (WAIT_CYCLES=4 -> 6 stalled cycles)
    run("t5.sw",  1, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 6, 2'd0, 0, 32'h0);
    run("t5.lw",  1, 1, 0, 3'b010, 32'h20, 32'h0,        6, 2'd0, 1, 32'hCAFEF00D);
    mem_read[1] = 1'b0; mem_write[1] = 1'b1; funct3[1] = 3'b001;
    addr[1] = 32'h22; wdata[1] = 32'h1234ABCD;
    @(posedge clk);   // first BUSY cycle
    @(posedge clk); #1;   // second BUSY cycle
    chk("t5.busy", {31'h0, stall[1]}, 32'h1);
    rst_n[1] = 1'b0;
    #1;
    chk("t5.rst_stall", {31'h0, stall[1]}, 32'h0);
    chk("t5.rst_fault", {31'h0, fault[1]}, 32'h0);
    chk("t5.rst_rdata", rdata[1], 32'h0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    release_req(1);
    @(posedge clk); #1;
    run("t5.after", 1, 1, 0, 3'b010, 32'h20, 32'h0, 6, 2'd0, 1, 32'hCAFEF00D);
    release_req(1);

    // 6: back-to-back SW/LW with WAIT_CYCLES=0, scoreboarded
    for (int i = 0; i < 16; i++) begin
      int          k;
      logic [31:0] wd;
      k  = (i / 2) % 4;
      wd = (32'h01010101 * 32'(i + 1)) ^ 32'hA5A50000;
      if (i % 2 == 0) begin
        model[k] = wd;
        run("t6.sw", 2, 0, 1, 3'b010, 32'h40 + 32'(4 * k), wd, 2, 2'd0, 0, 32'h0);
      end else begin
        run("t6.lw", 2, 1, 0, 3'b010, 32'h40 + 32'(4 * k), 32'h0, 2, 2'd0, 1, model[k]);
      end
    end
    release_req(2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
